convolution_procesor_mem_host: RTL and testbench
================================================

Name: convolution_procesor_mem_host

Overview:
- Memory and host-side counterpart of the convolution processor. It owns the Y sample RAM and the Z result RAM.
- On the Y side it answers the processor's memY_addr reads with dataY; on the Z side it accepts the processor's memZ_addr/dataZ/writeZ writes.
- Host side: accepts a Y sample stream (valid/ready), issues sizeY and a one-cycle start, waits for done, then streams Z back (valid/ready).
- Sits between the system bus/testbench host and convolution_procesor.

Parameters:
- DATA_WIDTH_DATAY, 8, Y sample width
- DATA_WIDTH_MEMY_ADDR, 5, Y RAM address width (depth 32)
- DATA_WIDTH_SIZEY, 5, sizeY width
- DATA_WIDTH_DATAZ, 16, Z result width
- DATA_WIDTH_MEMZ_ADDR, 6, Z RAM address width (depth 64)
- SIZEH, 10, kernel length; must match the processor's internal SIZEH

Ports:
- clk  in  1  clock; the single clock domain
- rstn  in  1  reset; asynchronous, active-low
- in_data  in  DATA_WIDTH_DATAY  host Y sample
- in_valid  in  1  in_data valid
- in_last  in  1  marks the final Y sample
- in_ready  out  1  block accepts a Y sample
- out_data  out  DATA_WIDTH_DATAZ  Z result to host
- out_valid  out  1  out_data valid
- out_last  out  1  marks the final Z sample
- out_ready  in  1  host accepts Z
- err_overflow  out  1  sticky: Y stream exceeded the RAM depth
- conv_sizeY  out  DATA_WIDTH_SIZEY  sample count to processor
- conv_start  out  1  start pulse to processor
- conv_busy  in  1  processor busy
- conv_done  in  1  processor done
- conv_memY_addr  in  DATA_WIDTH_MEMY_ADDR  processor Y read address
- conv_dataY  out  DATA_WIDTH_DATAY  Y read data
- conv_memZ_addr  in  DATA_WIDTH_MEMZ_ADDR  processor Z write address
- conv_dataZ  in  DATA_WIDTH_DATAZ  processor Z write data
- conv_writeZ  in  1  Z write enable

Behaviour:
- Reset values: all outputs 0 (in_ready, out_valid, out_last, out_data, conv_start, conv_sizeY, conv_dataY, err_overflow). FSM goes to IDLE; counters and the size register clear. RAM contents are not reset.
- Reset mid-operation (any state) aborts at once with no pulse on any output. A processor left running must be reset by the same rstn.

Y RAM:
- Write port is host-driven only in LOAD.
- Read port: conv_dataY is registered, 1-cycle latency from conv_memY_addr, and is active in every state.

Z RAM:
- Written when conv_writeZ=1 at conv_memZ_addr, in any state. Writes outside WAIT are also accepted.
- Read port is registered, 1-cycle latency.

FSM states: IDLE, LOAD, START, WAIT, DRAIN_RD, DRAIN_OUT.
- IDLE: in_ready=1. A transfer (in_valid & in_ready) writes Y[0], sets wcnt=1 and moves to LOAD. If in_last is also set, it moves directly to START with sizeY=1.
- LOAD: in_ready=1. Each transfer writes Y[wcnt] and increments wcnt. On in_last, sizeY := wcnt+1 and the FSM moves to START.
  - Overflow: a transfer at wcnt=31 without in_last is treated as last. sizeY=31, err_overflow:=1, go to START.
  - err_overflow is cleared only by reset or by the next accepted IDLE transfer.
- START: in_ready=0. conv_sizeY is driven from the size register and held stable until the next IDLE→LOAD. conv_start=1 for exactly one cycle, then go to WAIT.
- WAIT: in_ready=0. Stays until conv_done=1.
  - conv_done in the same cycle as the last conv_writeZ is legal; that write is committed.
  - On done: zcnt_total := sizeY + SIZEH − 1, computed at DATA_WIDTH_MEMZ_ADDR width with no overflow for the defaults (max 40). rptr := 0, go to DRAIN_RD.
  - conv_busy is ignored for sequencing; it is used only by assertions (busy must rise within 2 cycles of start).
- DRAIN_RD: present rptr to the Z read port, then go to DRAIN_OUT.
- DRAIN_OUT: out_valid=1 with out_data equal to the RAM output. out_last=1 when rptr = zcnt_total−1.
  - Data is held stable while out_ready=0.
  - On out_valid & out_ready: rptr increments. If last, go to IDLE; otherwise go to DRAIN_RD.
- Throughput: Z drain runs at 1 sample per 2 cycles max. Y load runs at 1 sample per cycle.
- The host may deassert in_valid at any time in LOAD; the FSM waits indefinitely.

Decomposition:
- Shared package convolution_procesor_pkg holds:
  - the state enum (IDLE…DRAIN_OUT)
  - the SIZEH constant, the same value used by the processor
  - width localparams
- One natural sub-module, convolution_procesor_dp_ram: 1 write port, 1 registered read port, parameterised width/depth. It is instantiated twice (Y, Z). No reset on the storage array.

Test Plan:
- Load Y=1,2,3 with in_last on 3 → conv_sizeY=3, conv_start high exactly 1 cycle, 1 cycle after the last transfer. in_ready=0 until the drain completes.
- Processor model reads conv_memY_addr=0,1,2 → conv_dataY=1,2,3, each 1 cycle after its address.
- Behavioural processor writes Z[i]=i*3 for i=0..11, then pulses done → host sees out_data 0,3,…,33: 12 samples, out_last only on 33. Then the FSM returns to IDLE with in_ready=1.
- out_ready held low 5 cycles mid-drain → out_data/out_valid stay stable, no sample lost or duplicated.
- 32 samples with no in_last → 32nd transfer forces START, conv_sizeY=31, err_overflow=1. Drain length 40. The next load clears err_overflow.
- rstn asserted in WAIT and in DRAIN_OUT (asynchronously, mid-cycle) → all outputs 0 immediately, state IDLE. The next single-sample load (in_last on first) gives conv_sizeY=1 and a drain length of 10.

Source files
------------

// File: rtl/convolution_procesor_pkg.sv
// rtl/convolution_procesor_pkg.sv - shared widths, kernel length and host FSM states
package convolution_procesor_pkg;

  localparam int DATAY_W      = 8;
  localparam int MEMY_ADDR_W  = 5;
  localparam int SIZEY_W      = 5;
  localparam int DATAZ_W      = 16;
  localparam int MEMZ_ADDR_W  = 6;
  // Kernel length; must equal the processor's internal SIZEH.
  localparam int KERNEL_SIZEH = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    DRAIN_RD,
    DRAIN_OUT
  } state_e;

endpackage

// File: rtl/convolution_procesor_dp_ram.sv
// rtl/convolution_procesor_dp_ram.sv - one write port, one registered read port
module convolution_procesor_dp_ram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the output register is reset so the read data starts at zero.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/convolution_procesor_mem_host.sv
// rtl/convolution_procesor_mem_host.sv - Y/Z RAMs and host sequencing for the convolution processor
module convolution_procesor_mem_host
  import convolution_procesor_pkg::*;
#(
  parameter int DATA_WIDTH_DATAY     = DATAY_W,
  parameter int DATA_WIDTH_MEMY_ADDR = MEMY_ADDR_W,
  parameter int DATA_WIDTH_SIZEY     = SIZEY_W,
  parameter int DATA_WIDTH_DATAZ     = DATAZ_W,
  parameter int DATA_WIDTH_MEMZ_ADDR = MEMZ_ADDR_W,
  parameter int SIZEH                = KERNEL_SIZEH
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [DATA_WIDTH_DATAY-1:0]     in_data,
  input  logic                            in_valid,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic [DATA_WIDTH_DATAZ-1:0]     out_data,
  output logic                            out_valid,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic                            err_overflow,
  output logic [DATA_WIDTH_SIZEY-1:0]     conv_sizeY,
  output logic                            conv_start,
  input  logic                            conv_busy,
  input  logic                            conv_done,
  input  logic [DATA_WIDTH_MEMY_ADDR-1:0] conv_memY_addr,
  output logic [DATA_WIDTH_DATAY-1:0]     conv_dataY,
  input  logic [DATA_WIDTH_MEMZ_ADDR-1:0] conv_memZ_addr,
  input  logic [DATA_WIDTH_DATAZ-1:0]     conv_dataZ,
  input  logic                            conv_writeZ
);

  localparam logic [DATA_WIDTH_MEMZ_ADDR-1:0] SIZEH_M1 = DATA_WIDTH_MEMZ_ADDR'(SIZEH - 1);

  state_e                          state_q;
  logic [DATA_WIDTH_MEMY_ADDR-1:0] wcnt_q;
  logic [DATA_WIDTH_SIZEY-1:0]     size_q;
  logic [DATA_WIDTH_MEMZ_ADDR-1:0] rptr_q, ztot_q, ztot_d;
  logic                            in_ready_q, out_valid_q, out_last_q, start_q, err_q;
  logic                            in_fire, out_fire, y_full;
  logic [DATA_WIDTH_MEMY_ADDR-1:0] y_waddr;
  logic [DATA_WIDTH_DATAZ-1:0]     z_rdata;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;
  assign y_full   = (wcnt_q == '1);
  assign y_waddr  = (state_q == IDLE) ? '0 : wcnt_q;
  assign ztot_d   = DATA_WIDTH_MEMZ_ADDR'(size_q) + SIZEH_M1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      size_q      <= '0;
      rptr_q      <= '0;
      ztot_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_fire) begin
            err_q  <= 1'b0;
            wcnt_q <= DATA_WIDTH_MEMY_ADDR'(1);
            if (in_last) begin
              size_q     <= DATA_WIDTH_SIZEY'(1);
              start_q    <= 1'b1;
              in_ready_q <= 1'b0;
              state_q    <= START;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (in_fire) begin
            wcnt_q <= wcnt_q + 1'b1;
            // The last RAM slot closes the load even without in_last; sizeY saturates at 31.
            if (in_last || y_full) begin
              size_q     <= y_full ? '1 : DATA_WIDTH_SIZEY'(wcnt_q + 1'b1);
              err_q      <= y_full & ~in_last;
              start_q    <= 1'b1;
              in_ready_q <= 1'b0;
              state_q    <= START;
            end
          end
        end
        START: state_q <= WAIT;
        WAIT: begin
          if (conv_done) begin
            ztot_q  <= ztot_d;
            rptr_q  <= '0;
            state_q <= DRAIN_RD;
          end
        end
        DRAIN_RD: begin
          out_valid_q <= 1'b1;
          out_last_q  <= (rptr_q == ztot_q - 1'b1);
          state_q     <= DRAIN_OUT;
        end
        DRAIN_OUT: begin
          if (out_fire) begin
            rptr_q      <= rptr_q + 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              in_ready_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              state_q <= DRAIN_RD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  convolution_procesor_dp_ram #(.WIDTH(DATA_WIDTH_DATAY), .ADDR_W(DATA_WIDTH_MEMY_ADDR)) u_ram_y (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .we_i    (in_fire),
    .waddr_i (y_waddr),
    .wdata_i (in_data),
    .re_i    (1'b1),
    .raddr_i (conv_memY_addr),
    .rdata_o (conv_dataY)
  );

  // Z is only read in DRAIN_RD so the presented sample holds through back-pressure.
  convolution_procesor_dp_ram #(.WIDTH(DATA_WIDTH_DATAZ), .ADDR_W(DATA_WIDTH_MEMZ_ADDR)) u_ram_z (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .we_i    (conv_writeZ),
    .waddr_i (conv_memZ_addr),
    .wdata_i (conv_dataZ),
    .re_i    (state_q == DRAIN_RD),
    .raddr_i (rptr_q),
    .rdata_o (z_rdata)
  );

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign out_data     = out_valid_q ? z_rdata : '0;
  assign conv_start   = start_q;
  assign conv_sizeY   = size_q;
  assign err_overflow = err_q;

  busy_after_start: assert property (@(posedge clk) disable iff (!rstn)
    $past(start_q, 2) |-> (conv_busy || $past(conv_busy)));

endmodule

// File: tb/tb_convolution_procesor_mem_host.sv
// tb/tb_convolution_procesor_mem_host.sv - scoreboard bench for convolution_procesor_mem_host
module tb_convolution_procesor_mem_host;
  import convolution_procesor_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [15:0] out_data;
  logic        out_valid, out_last, out_ready = 1'b0;
  logic        err_overflow;
  logic [4:0]  conv_sizeY;
  logic        conv_start;
  logic        conv_busy = 1'b0, conv_done = 1'b0;
  logic [4:0]  conv_memY_addr = '0;
  logic [7:0]  conv_dataY;
  logic [5:0]  conv_memZ_addr = '0;
  logic [15:0] conv_dataZ = '0;
  logic        conv_writeZ = 1'b0;

  always #5 clk = ~clk;

  convolution_procesor_mem_host dut (
    .clk(clk), .rstn(rstn),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .err_overflow(err_overflow), .conv_sizeY(conv_sizeY), .conv_start(conv_start),
    .conv_busy(conv_busy), .conv_done(conv_done),
    .conv_memY_addr(conv_memY_addr), .conv_dataY(conv_dataY),
    .conv_memZ_addr(conv_memZ_addr), .conv_dataZ(conv_dataZ), .conv_writeZ(conv_writeZ)
  );

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } zexp_t;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_pop    = 0;
  zexp_t exp_q[$];
  zexp_t mon_e;
  logic [7:0] y_model [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard on every Z handshake and checks hold-stability while stalled.
  logic        stall_seen = 1'b0;
  logic [15:0] stall_data;
  logic        stall_last;
  always @(negedge clk) begin
    if (!rstn) begin
      stall_seen = 1'b0;
    end else if (out_valid && !out_ready) begin
      if (stall_seen) begin
        check("stall_data", out_data, stall_data);
        check("stall_last", out_last, stall_last);
      end
      stall_seen = 1'b1;
      stall_data = out_data;
      stall_last = out_last;
    end else begin
      stall_seen = 1'b0;
      if (out_valid && out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          check("z_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("z_data", out_data, mon_e.data);
          check("z_last", out_last, mon_e.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_y(input logic [7:0] d, input logic last);
    bit ok = 1'b0;
    int guard = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    while (!ok && guard < 50) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      guard++;
    end
    if (!ok) check("in_ready_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Behavioural processor: called in the START cycle; reads Y, writes Z[i]=i*mul, done with last write.
  task automatic run_proc(input int size, input int mul);
    int    nz = size + KERNEL_SIZEH - 1;
    zexp_t e;
    conv_busy = 1'b1;
    tick();
    check("start_one_cycle", conv_start, 0);
    for (int i = 0; i < size; i++) begin
      conv_memY_addr = 5'(i);
      tick();
      check("dataY", conv_dataY, y_model[i]);
    end
    check("in_ready_wait", in_ready, 0);
    for (int i = 0; i < nz; i++) begin
      conv_memZ_addr = 6'(i);
      conv_dataZ     = 16'(i * mul);
      conv_writeZ    = 1'b1;
      conv_done      = (i == nz - 1);
      e.last = (i == nz - 1);
      e.data = 16'(i * mul);
      exp_q.push_back(e);
      tick();
    end
    conv_writeZ = 1'b0;
    conv_done   = 1'b0;
    conv_busy   = 1'b0;
  endtask

  task automatic wait_drain(input int nz, input int stall_at);
    int start_pop = n_pop;
    int guard = 0;
    int s = stall_at;
    out_ready = 1'b1;
    while ((n_pop - start_pop) < nz && guard < 500) begin
      if (s >= 0 && (n_pop - start_pop) == s) begin
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        s = -1;
      end
      tick();
      guard++;
    end
    check("drain_len", n_pop - start_pop, nz);
    repeat (2) tick();
    check("drain_no_extra", n_pop - start_pop, nz);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_start"}, conv_start, 0);
    check({tag, "_sizeY"}, conv_sizeY, 0);
    check({tag, "_dataY"}, conv_dataY, 0);
    check({tag, "_err"}, err_overflow, 0);
  endtask

  task automatic mid_cycle_reset(input string tag);
    #2 rstn = 1'b0;
    #1 check_zero(tag);
    conv_busy = 1'b0;
    exp_q.delete();
    tick();
    rstn = 1'b1;
    tick();
    check({tag, "_idle_in_ready"}, in_ready, 1);
  endtask

  initial begin
    repeat (3) tick();
    check_zero("reset");
    rstn = 1'b1;
    tick();
    check("in_ready_after_reset", in_ready, 1);

    // Three-sample load, stalled drain.
    y_model[0] = 8'd1; y_model[1] = 8'd2; y_model[2] = 8'd3;
    send_y(8'd1, 1'b0);
    send_y(8'd2, 1'b0);
    check("start_not_early", conv_start, 0);
    send_y(8'd3, 1'b1);
    check("start_pulse", conv_start, 1);
    check("sizeY_3", conv_sizeY, 3);
    check("in_ready_start", in_ready, 0);
    run_proc(3, 3);
    wait_drain(12, 5);
    check("sizeY_held", conv_sizeY, 3);

    // Overflow: 32 samples without in_last.
    for (int k = 0; k < 32; k++) begin
      y_model[k] = 8'(k * 5 + 7);
      send_y(y_model[k], 1'b0);
    end
    check("ovf_start", conv_start, 1);
    check("ovf_sizeY", conv_sizeY, 31);
    check("ovf_err", err_overflow, 1);
    run_proc(31, 3);
    wait_drain(40, -1);
    check("ovf_err_sticky", err_overflow, 1);

    // Single sample clears the error; reset while in WAIT.
    y_model[0] = 8'h5A;
    send_y(8'h5A, 1'b1);
    check("err_cleared", err_overflow, 0);
    check("single_sizeY", conv_sizeY, 1);
    conv_busy = 1'b1;
    repeat (4) tick();
    check("wait_in_ready", in_ready, 0);
    mid_cycle_reset("rst_wait");

    // Reset while presenting a Z sample in DRAIN_OUT.
    y_model[0] = 8'h11;
    out_ready = 1'b0;
    send_y(8'h11, 1'b1);
    run_proc(1, 7);
    for (int g = 0; g < 20 && !out_valid; g++) tick();
    check("reached_drain_out", out_valid, 1);
    mid_cycle_reset("rst_drain");

    y_model[0] = 8'h22;
    send_y(8'h22, 1'b1);
    check("post_rst_sizeY", conv_sizeY, 1);
    check("post_rst_start", conv_start, 1);
    run_proc(1, 7);
    wait_drain(10, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
